// File: rtl/tick_period_monitor_if.sv
// -----------------------------------------------------------------------------
// tick_period_monitor_if
//   Bundles the tick input, the measurement valid/ready port and the status
//   pulses of tick_period_monitor.
//
//   Handshake: period_out is offered while period_valid is high and is taken by
//   the consumer on a rising clock edge where period_valid && period_ready.
//   period_valid does not depend on period_ready. A new measurement arriving
//   while the held one is still untaken replaces it and raises overrun.
//
//   master : monitor side. It drives the measurement, status and debug state.
//   slave  : environment side. It drives tick_in and period_ready.
//
//   Signals
//     tick_in       divider enable, one-cycle pulse per tick
//     period_out    last measured period, in clock cycles
//     period_valid  period_out holds an unconsumed measurement
//     period_ready  consumer accepts period_out this edge
//     locked        monitor is in the LOCKED state
//     fault         one-cycle pulse: lock lost or tick timeout
//     overrun       one-cycle pulse: unconsumed measurement overwritten
//     dbg_state     FSM state (0 IDLE, 1 ACQUIRE, 2 LOCKED)
// -----------------------------------------------------------------------------
interface tick_period_monitor_if #(
    parameter int CNT_W = 5
);
    logic             tick_in;
    logic [CNT_W-1:0] period_out;
    logic             period_valid;
    logic             period_ready;
    logic             locked;
    logic             fault;
    logic             overrun;
    logic [1:0]       dbg_state;

    modport master (
        input  tick_in,
        input  period_ready,
        output period_out,
        output period_valid,
        output locked,
        output fault,
        output overrun,
        output dbg_state
    );

    modport slave (
        output tick_in,
        output period_ready,
        input  period_out,
        input  period_valid,
        input  locked,
        input  fault,
        input  overrun,
        input  dbg_state
    );
endinterface

// File: rtl/tick_period_monitor.sv
// -----------------------------------------------------------------------------
// tick_period_monitor
//   Measures the spacing, in clk_in cycles, between the single-cycle enable
//   ticks of a clock divider. Each period is checked against
//   NOMINAL = CLK_IN/TICK_RATE +/- TOLERANCE. LOCK_COUNT consecutive in-range
//   periods assert locked. A bad period while locked, or a missing tick for
//   MAX_PERIOD = 2*NOMINAL cycles, raises a one-cycle fault pulse. Each
//   measurement is offered through a one-entry valid/ready holding register.
//
//   Ports
//     clk_in    clock
//     reset     asynchronous, active-high reset
//     bus       tick_period_monitor_if.master. It carries tick_in,
//               period_out/period_valid/period_ready, locked, fault, overrun
//               and dbg_state.
//     err_count present only with TICK_MON_STATS_EN. This is a saturating
//               8-bit count of out-of-range measurements and timeouts.
//
//   Optional feature macro: TICK_MON_STATS_EN
//
//   All outputs are registered. They change on the edge that ends the cycle
//   in which the tick was seen.
// -----------------------------------------------------------------------------
module tick_period_monitor #(
    parameter int CLK_IN     = 12000000,
    parameter int TICK_RATE  = 1000000,
    parameter int TOLERANCE  = 1,
    parameter int LOCK_COUNT = 4
) (
    input  logic                       clk_in,
    input  logic                       reset,
    tick_period_monitor_if.master      bus
`ifdef TICK_MON_STATS_EN
    ,
    output logic [7:0]                 err_count
`endif
);

    localparam int NOMINAL    = CLK_IN / TICK_RATE;
    localparam int MAX_PERIOD = 2 * NOMINAL;
    localparam int CNT_W      = $clog2(MAX_PERIOD + 1);
    localparam int LC_W       = $clog2(LOCK_COUNT + 1);

    // The lower bound clamps at 0 instead of wrapping. The upper bound clamps
    // at MAX_PERIOD, because the counter can never exceed that value.
    localparam int LO_INT = (TOLERANCE >= NOMINAL) ? 0 : NOMINAL - TOLERANCE;
    localparam int HI_INT = (NOMINAL + TOLERANCE > MAX_PERIOD) ? MAX_PERIOD
                                                               : NOMINAL + TOLERANCE;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0] LO_CNT  = CNT_W'(LO_INT);
    localparam logic [CNT_W-1:0] HI_CNT  = CNT_W'(HI_INT);
    localparam logic [LC_W-1:0]  LC_LAST = LC_W'(LOCK_COUNT - 1);
    localparam logic [LC_W-1:0]  LC_FULL = LC_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [LC_W-1:0]  r_lock_cnt;
    logic [LC_W-1:0]  w_lock_cnt_nxt;
    logic             w_fault_nxt;
    logic [CNT_W-1:0] r_period;
    logic             r_valid;
    logic             r_fault;
    logic             r_overrun;

    logic w_tick;
    logic w_in_range;
    logic w_meas;
    logic w_timeout;

    assign w_tick     = bus.tick_in;
    assign w_in_range = (r_cnt >= LO_CNT) && (r_cnt <= HI_CNT);
    // The first tick after IDLE only starts the reference. It produces no period.
    assign w_meas     = w_tick && (r_state != ST_IDLE);
    // A tick on the saturation cycle wins over the timeout. It is measured instead.
    assign w_timeout  = (r_state != ST_IDLE) && !w_tick && (r_cnt == MAX_CNT);

    // Cycles since the last tick. The counter restarts at 1, so a tick that
    // arrives p cycles after the previous one sees r_cnt == p.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= CNT_W'(1);
        end else if (r_cnt != MAX_CNT) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_lock_cnt <= '0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_fault    <= w_fault_nxt;
        end
    end

    // FSM next state, lock counter and fault pulse
    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        w_fault_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_lock_cnt_nxt = '0;
                if (w_tick) begin
                    w_state_nxt = ST_ACQUIRE;
                end
            end
            ST_ACQUIRE: begin
                if (w_tick) begin
                    if (w_in_range) begin
                        if (r_lock_cnt >= LC_LAST) begin
                            w_state_nxt    = ST_LOCKED;
                            w_lock_cnt_nxt = LC_FULL;
                        end else begin
                            w_lock_cnt_nxt = r_lock_cnt + LC_W'(1);
                        end
                    end else begin
                        // An out-of-range period before lock only restarts the count.
                        w_lock_cnt_nxt = '0;
                    end
                end else if (w_timeout) begin
                    w_state_nxt    = ST_IDLE;
                    w_lock_cnt_nxt = '0;
                    w_fault_nxt    = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (w_tick) begin
                    if (!w_in_range) begin
                        w_state_nxt    = ST_ACQUIRE;
                        w_lock_cnt_nxt = '0;
                        w_fault_nxt    = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_nxt    = ST_IDLE;
                    w_lock_cnt_nxt = '0;
                    w_fault_nxt    = 1'b1;
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_lock_cnt_nxt = '0;
            end
        endcase
    end

    // One-entry holding register. A new measurement always loads. It counts as
    // an overrun only when the old value was neither taken before nor taken in
    // this same cycle.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_period  <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_meas) begin
                r_period  <= r_cnt;
                r_valid   <= 1'b1;
                r_overrun <= r_valid && !bus.period_ready;
            end else if (r_valid && bus.period_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef TICK_MON_STATS_EN
    logic [7:0] r_err_count;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (((w_meas && !w_in_range) || w_timeout) && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`endif

    assign bus.period_out   = r_period;
    assign bus.period_valid = r_valid;
    assign bus.locked       = (r_state == ST_LOCKED);
    assign bus.fault        = r_fault;
    assign bus.overrun      = r_overrun;
    assign bus.dbg_state    = r_state;

endmodule
